// File: rtl/obj_dma.sv
// Object-entry DMA: copies 4*ENTRIES 16-bit sprite RAM words into 64-bit entries.
// Define OBJ_DMA_DOUBLE_BUFFER_EN for a vblank-swapped fill/display bank pair.
module obj_dma #(
  parameter int ENTRIES = 512
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce,
  input  logic        dma_trig,
  input  logic        vpulse,
  output logic [10:0] src_addr,
  input  logic [15:0] src_data,
  input  logic [8:0]  obj_idx,
  output logic [63:0] obj_in,
  output logic        busy,
  output logic        dma_done
);
  localparam int IW = $clog2(ENTRIES);
  localparam int KW = IW + 2;
  localparam logic [12:0] LAST = 13'(4 * ENTRIES);

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic        pending_q, pending_d;
  logic [12:0] w_q, w_d;
  logic [10:0] src_addr_q, src_addr_d;
  logic [47:0] asm_q, asm_d;
  logic        done_q, done_d;
  logic [63:0] obj_in_q, rd_data;

  logic [KW-1:0] k;
  logic          we;
  logic [IW-1:0] wr_idx;
  logic [63:0]   wr_data;

`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
  logic ready_q, ready_d;
  logic bank_q, bank_d;
`endif

  // k is the word whose data arrives this ce (address was issued one ce earlier)
  assign k       = w_q[KW-1:0] - KW'(1);
  assign wr_idx  = k[KW-1:2];
  assign wr_data = {src_data, asm_q};

  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q | dma_trig;
    w_d        = w_q;
    src_addr_d = src_addr_q;
    asm_d      = asm_q;
    done_d     = 1'b0;
    we         = 1'b0;
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
    ready_d    = ready_q;
    bank_d     = bank_q;
`endif
    if (ce) begin
      case (state_q)
        IDLE: if (pending_q) begin
          state_d   = RUN;
          pending_d = dma_trig;
          w_d       = 13'd0;
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
          ready_d   = 1'b0;
`endif
        end
        RUN: begin
          if (w_q < LAST) src_addr_d = w_q[10:0];
          if (w_q != 13'd0) begin
            case (k[1:0])
              2'd0: asm_d[15:0]  = src_data;
              2'd1: asm_d[31:16] = src_data;
              2'd2: asm_d[47:32] = src_data;
              2'd3: we           = 1'b1;
            endcase
          end
          w_d = w_q + 13'd1;
          if (w_q == LAST) begin
            state_d = IDLE;
            done_d  = 1'b1;
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
            ready_d = 1'b1;
`endif
          end
        end
        default: state_d = IDLE;
      endcase
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
      // ready is never set on entry to this ce when a copy just finished, so no same-ce swap
      if (vpulse && ready_q) begin
        bank_d  = ~bank_q;
        ready_d = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pending_q  <= 1'b0;
      w_q        <= 13'd0;
      src_addr_q <= 11'd0;
      asm_q      <= 48'd0;
      done_q     <= 1'b0;
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
      ready_q    <= 1'b0;
      bank_q     <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      w_q        <= w_d;
      src_addr_q <= src_addr_d;
      asm_q      <= asm_d;
      done_q     <= done_d;
`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
      ready_q    <= ready_d;
      bank_q     <= bank_d;
`endif
    end
  end

`ifdef OBJ_DMA_DOUBLE_BUFFER_EN
  logic [63:0] mem [2][ENTRIES];

  always_ff @(posedge clk) begin
    if (we) mem[~bank_q][wr_idx] <= wr_data;
  end

  assign rd_data = mem[bank_q][obj_idx[IW-1:0]];
`else
  logic [63:0] mem [ENTRIES];
  logic        unused_vpulse;

  assign unused_vpulse = vpulse;

  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_data;
  end

  assign rd_data = mem[obj_idx[IW-1:0]];
`endif

  // Read port runs every clk so the line engine is never stalled by ce
  always_ff @(posedge clk or posedge reset) begin
    if (reset) obj_in_q <= 64'd0;
    else       obj_in_q <= rd_data;
  end

  assign src_addr = src_addr_q;
  assign obj_in   = obj_in_q;
  assign busy     = (state_q == RUN);
  assign dma_done = done_q;
endmodule
